pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: REG_AW, default 5, register-specifier width.
REQ-002 Parameter: BR_EXTRA, default 1, range 0..3, extra branch bubble cycles after the taken-branch cycle.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Ports: id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID.
REQ-006 Ports: exe_rd  in  REG_AW  destination register in EXE; exe_is_load  in  1  EXE holds a load.
REQ-007 Port: br_taken  in  1  taken branch/jump resolved in EXE.
REQ-008 Ports: mem_req  in  1  MEM stage accesses data memory; mem_ready  in  1  access completes this cycle.
REQ-009 Ports: halt_req  in  1  halt instruction in WB; resume  in  1  single-cycle restart pulse.
REQ-010 Ports: if_en, id_en, exe_en, mem_en, wb_en  out  1 each  load enables for PC, IF_ID, ID_EXE, EXE_MEM, MEM_WB registers.
REQ-011 Ports: id_flush, exe_flush  out  1 each  load a bubble (NOP, zero IR) into IF_ID / ID_EXE.
REQ-012 Ports: pc_load  out  1  PC takes branch target; halted  out  1  pipeline stopped.

Function
REQ-013 States: RUN, MEM_WAIT, FLUSH, HALT; 2-bit state register plus 2-bit flush counter.
REQ-014 All outputs are combinational from state and inputs (zero-cycle latency); state changes on the next posedge.
REQ-015 Priority within a cycle, highest first: halt_req, memory stall, taken branch, load-use stall.
REQ-016 RUN, no events: all five enables 1, flushes 0, pc_load 0.
REQ-017 RUN, mem_req=1 and mem_ready=0: all enables 0, no flush; next state MEM_WAIT.
REQ-018 MEM_WAIT: all enables 0 while mem_ready=0; on mem_ready=1, all enables 1 that cycle, next state RUN.
REQ-019 Branch and load-use are evaluated only in cycles where the memory stall is not active.
REQ-020 RUN, br_taken=1: pc_load=1, id_flush=1, exe_flush=1, all enables 1; if BR_EXTRA>0 load counter with BR_EXTRA, next state FLUSH.
REQ-021 FLUSH: enables 1, id_flush=1, pc_load=0; decrement counter each cycle; counter reaching 1 returns to RUN; br_taken ignored.
REQ-022 Load-use: exe_is_load=1, exe_rd!=0, exe_rd equals id_rs1 or id_rs2 -> if_en=0, id_en=0, exe_flush=1, others 1; one cycle only.
REQ-023 Load-use coincident with br_taken: branch handling wins, no extra stall.
REQ-024 halt_req=1 in any state: all enables 0 that cycle, next state HALT.
REQ-025 HALT: all enables 0, halted=1; resume=1 returns to RUN next cycle, enables stay 0 during the resume cycle.
REQ-026 Reset in any state aborts sequencing; no partial FLUSH or MEM_WAIT survives.

Reset
REQ-027 rst_n=0 asynchronously forces RUN, counter 0, all enables 0, flushes 0, pc_load 0, halted 0.
REQ-028 First posedge after rst_n rises: RUN behaviour per REQ-016.

Configuration
REQ-029 Macro PIPE_STALL_CNT_EN: when defined, adds output stall_cnt (16 bits, reset 0), incrementing each cycle if_en=0 outside HALT, saturating at 0xFFFF.
REQ-030 Without PIPE_STALL_CNT_EN: no stall_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-031 exe_is_load=1, exe_rd=3, id_rs2=3 for one cycle -> if_en=0, id_en=0, exe_flush=1 that cycle; next cycle all enables 1.
REQ-032 exe_is_load=1, exe_rd=0, id_rs1=0 -> no stall, all enables 1.
REQ-033 mem_req=1, mem_ready low 3 cycles then high -> enables 0 for 3 cycles, 1 on ready cycle; stall_cnt=3 with macro.
REQ-034 BR_EXTRA=2, br_taken pulse -> cycle0 pc_load=1, id_flush=1, exe_flush=1; cycles1-2 id_flush=1; cycle3 RUN.
REQ-035 halt_req pulse then resume 5 cycles later -> halted=1 for 6 cycles, enables 0 throughout, RUN after resume.
REQ-036 rst_n low mid-FLUSH and mid-MEM_WAIT -> outputs immediately at REQ-027 values, RUN after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush/halt controller with branch bubble sequencing.
// Optional PIPE_STALL_CNT_EN adds a saturating 16-bit stall cycle counter output.
module pipe_ctrl #(
  parameter int REG_AW   = 5,
  parameter int BR_EXTRA = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] exe_rd,
  input  logic              exe_is_load,
  input  logic              br_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              halt_req,
  input  logic              resume,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              id_flush,
  output logic              exe_flush,
  output logic              pc_load,
  output logic              halted
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, HALT} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic run_en, fe_stall, id_fl, ex_fl, pcl, load_use, mem_stall;
  always_comb begin
    load_use  = exe_is_load && (exe_rd != '0) && (exe_rd == id_rs1 || exe_rd == id_rs2);
    mem_stall = (state_q == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_en    = 1'b0;
    fe_stall  = 1'b0;
    id_fl     = 1'b0;
    ex_fl     = 1'b0;
    pcl       = 1'b0;
    if (halt_req) begin
      state_d = HALT;
      cnt_d   = 2'd0;
    end else if (state_q == HALT) begin
      state_d = resume ? RUN : HALT;
    end else if (state_q == FLUSH) begin
      // a memory stall freezes the bubble sequence in place
      if (!mem_stall) begin
        run_en  = 1'b1;
        id_fl   = 1'b1;
        state_d = (cnt_q <= 2'd1) ? RUN : FLUSH;
        cnt_d   = (cnt_q <= 2'd1) ? 2'd0 : cnt_q - 2'd1;
      end
    end else if (mem_stall) begin
      state_d = MEM_WAIT;
    end else begin
      run_en   = 1'b1;
      pcl      = br_taken;
      id_fl    = br_taken;
      ex_fl    = br_taken || load_use;
      fe_stall = !br_taken && load_use;
      state_d  = (br_taken && BR_EXTRA > 0) ? FLUSH : RUN;
      cnt_d    = (br_taken && BR_EXTRA > 0) ? 2'(BR_EXTRA) : 2'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // rst_n gates the outputs so reset forces them low without waiting for a clock
  assign if_en     = rst_n && run_en && !fe_stall;
  assign id_en     = rst_n && run_en && !fe_stall;
  assign exe_en    = rst_n && run_en;
  assign mem_en    = rst_n && run_en;
  assign wb_en     = rst_n && run_en;
  assign id_flush  = rst_n && id_fl;
  assign exe_flush = rst_n && ex_fl;
  assign pc_load   = rst_n && pcl;
  assign halted    = rst_n && (halt_req || state_q == HALT);
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb
    stall_d = (!if_en && state_q != HALT && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 16'd0;
    else        stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule
